// File: rtl/axis_demux_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_demux_if
//  Description : Bundles the upstream AXI-Stream port, both downstream ports
//                and the per-port delivered-packet counters of axis_demux.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_demux_if #(
  parameter int DATA_WIDTH = 8
);
  // Upstream beat
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tlast;
  logic                  s_axis_tdest;

  // Downstream port 1
  logic                  m_axis_tvalid1;
  logic                  m_axis_tready1;
  logic [DATA_WIDTH-1:0] m_axis_tdata1;
  logic                  m_axis_tlast1;

  // Downstream port 2
  logic                  m_axis_tvalid2;
  logic                  m_axis_tready2;
  logic [DATA_WIDTH-1:0] m_axis_tdata2;
  logic                  m_axis_tlast2;

  // Delivered-packet counters
  logic [7:0]            pkt_cnt1;
  logic [7:0]            pkt_cnt2;

  // Demux side
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tdest,
    input  m_axis_tready1, m_axis_tready2,
    output s_axis_tready,
    output m_axis_tvalid1, m_axis_tdata1, m_axis_tlast1,
    output m_axis_tvalid2, m_axis_tdata2, m_axis_tlast2,
    output pkt_cnt1, pkt_cnt2
  );

  // Environment side (source upstream, sink downstream)
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tdest,
    output m_axis_tready1, m_axis_tready2,
    input  s_axis_tready,
    input  m_axis_tvalid1, m_axis_tdata1, m_axis_tlast1,
    input  m_axis_tvalid2, m_axis_tdata2, m_axis_tlast2,
    input  pkt_cnt1, pkt_cnt2
  );
endinterface
`default_nettype wire

// File: rtl/axis_demux.sv
`default_nettype none
// ============================================================================
//  Module      : axis_demux
//  Description : 1-to-2 AXI-Stream packet demultiplexer. Destination is taken
//                from the first beat of each packet; each output has a single
//                registered beat slot; per-port delivered-packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_demux #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic  aclk,
  input  wire logic  aresetn,
  axis_demux_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY1 = 2'd1,
    BUSY2 = 2'd2
  } state_t;

  state_t                r_state;

  logic                  r_valid1;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_last1;
  logic                  r_valid2;
  logic [DATA_WIDTH-1:0] r_data2;
  logic                  r_last2;
  logic [7:0]            r_cnt1;
  logic [7:0]            r_cnt2;

  logic                  w_sel2;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_load1;
  logic                  w_load2;
  logic                  w_fire1;
  logic                  w_fire2;

  // Port select: destination bit on a first beat, locked to the packet's port otherwise
  always_comb begin
    w_sel2 = 1'b0;
    case (r_state)
      IDLE:    w_sel2 = bus.s_axis_tdest;
      BUSY1:   w_sel2 = 1'b0;
      BUSY2:   w_sel2 = 1'b1;
      default: w_sel2 = 1'b0;
    endcase
  end

  // Ready is held low throughout reset so nothing is accepted while state is cleared
  assign w_tready = aresetn & (w_sel2 ? (~r_valid2 | bus.m_axis_tready2)
                                      : (~r_valid1 | bus.m_axis_tready1));
  assign w_accept = bus.s_axis_tvalid & w_tready;
  assign w_load1  = w_accept & ~w_sel2;
  assign w_load2  = w_accept &  w_sel2;
  assign w_fire1  = r_valid1 & bus.m_axis_tready1;
  assign w_fire2  = r_valid2 & bus.m_axis_tready2;

  // Packet-tracking FSM: advances only on accepted beats
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      case (r_state)
        IDLE:         if (!bus.s_axis_tlast) r_state <= bus.s_axis_tdest ? BUSY2 : BUSY1;
        BUSY1, BUSY2: if (bus.s_axis_tlast)  r_state <= IDLE;
        default:      r_state <= IDLE;
      endcase
    end
  end

  // Port 1 slot: a load wins over a drain in the same cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid1 <= 1'b0;
      r_data1  <= '0;
      r_last1  <= 1'b0;
    end else if (w_load1) begin
      r_valid1 <= 1'b1;
      r_data1  <= bus.s_axis_tdata;
      r_last1  <= bus.s_axis_tlast;
    end else if (w_fire1) begin
      r_valid1 <= 1'b0;
      r_data1  <= '0;
      r_last1  <= 1'b0;
    end
  end

  // Port 2 slot: a load wins over a drain in the same cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid2 <= 1'b0;
      r_data2  <= '0;
      r_last2  <= 1'b0;
    end else if (w_load2) begin
      r_valid2 <= 1'b1;
      r_data2  <= bus.s_axis_tdata;
      r_last2  <= bus.s_axis_tlast;
    end else if (w_fire2) begin
      r_valid2 <= 1'b0;
      r_data2  <= '0;
      r_last2  <= 1'b0;
    end
  end

  // Delivered-packet counters: count downstream handshakes carrying tlast, wrap at 256
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt1 <= 8'd0;
      r_cnt2 <= 8'd0;
    end else begin
      if (w_fire1 && r_last1) r_cnt1 <= r_cnt1 + 8'd1;
      if (w_fire2 && r_last2) r_cnt2 <= r_cnt2 + 8'd1;
    end
  end

  assign bus.s_axis_tready  = w_tready;
  assign bus.m_axis_tvalid1 = r_valid1;
  assign bus.m_axis_tdata1  = r_data1;
  assign bus.m_axis_tlast1  = r_last1;
  assign bus.m_axis_tvalid2 = r_valid2;
  assign bus.m_axis_tdata2  = r_data2;
  assign bus.m_axis_tlast2  = r_last2;
  assign bus.pkt_cnt1       = r_cnt1;
  assign bus.pkt_cnt2       = r_cnt2;

endmodule
`default_nettype wire

// File: tb/tb_axis_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_demux
//  Description : Self-checking bench for axis_demux: directed vector table
//                plus hand-written sequences for counter wrap and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_demux;

  logic aclk;
  logic aresetn;
  int   n_tests;
  int   n_fail;

  axis_demux_if #(.DATA_WIDTH(8)) bus();

  axis_demux #(.DATA_WIDTH(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // 10 ns clock
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic       dst;
    logic       r1;
    logic       r2;
    logic       e_rdy;
    logic       ev1;
    logic [7:0] ed1;
    logic       el1;
    logic       ev2;
    logic [7:0] ed2;
    logic       el2;
    logic [7:0] ec1;
    logic [7:0] ec2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic tv, logic [7:0] td, logic tl, logic dst,
                              logic r1, logic r2, logic e_rdy,
                              logic ev1, logic [7:0] ed1, logic el1,
                              logic ev2, logic [7:0] ed2, logic el2,
                              logic [7:0] ec1, logic [7:0] ec2);
    vec_t v;
    v.tv = tv;   v.td = td;   v.tl = tl;   v.dst = dst;
    v.r1 = r1;   v.r2 = r2;   v.e_rdy = e_rdy;
    v.ev1 = ev1; v.ed1 = ed1; v.el1 = el1;
    v.ev2 = ev2; v.ed2 = ed2; v.el2 = el2;
    v.ec1 = ec1; v.ec2 = ec2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic tv, input logic [7:0] td, input logic tl,
                       input logic dst, input logic r1, input logic r2);
    bus.s_axis_tvalid  = tv;
    bus.s_axis_tdata   = td;
    bus.s_axis_tlast   = tl;
    bus.s_axis_tdest   = dst;
    bus.m_axis_tready1 = r1;
    bus.m_axis_tready2 = r2;
  endtask

  task automatic chk_outputs(input string tag,
                             input logic ev1, input logic [7:0] ed1, input logic el1,
                             input logic ev2, input logic [7:0] ed2, input logic el2,
                             input logic [7:0] ec1, input logic [7:0] ec2);
    chk({tag, " tvalid1"}, 32'(bus.m_axis_tvalid1), 32'(ev1));
    chk({tag, " tdata1"},  32'(bus.m_axis_tdata1),  32'(ed1));
    chk({tag, " tlast1"},  32'(bus.m_axis_tlast1),  32'(el1));
    chk({tag, " tvalid2"}, 32'(bus.m_axis_tvalid2), 32'(ev2));
    chk({tag, " tdata2"},  32'(bus.m_axis_tdata2),  32'(ed2));
    chk({tag, " tlast2"},  32'(bus.m_axis_tlast2),  32'(el2));
    chk({tag, " pkt_cnt1"}, 32'(bus.pkt_cnt1), 32'(ec1));
    chk({tag, " pkt_cnt2"}, 32'(bus.pkt_cnt2), 32'(ec2));
  endtask

  // Reset with tvalid high so the reset-time ready gating is exercised
  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge aclk);
    chk("reset s_tready", 32'(bus.s_axis_tready), 32'd0);
    chk_outputs("reset", 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    aresetn = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    aresetn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    //      tv td    tl dst r1 r2 rdy  v1 d1    l1  v2 d2    l2  c1 c2
    // single beat to port 2
    vecs.push_back(mk(1, 8'hA5, 1, 1, 1, 1, 1,  0, 8'h00, 0,  1, 8'hA5, 1,  0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0,  0, 1));
    // 4-beat packet to port 1, tdest toggled after first beat, one source stall
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 1,  1, 8'h01, 0,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(1, 8'h02, 0, 1, 1, 1, 1,  1, 8'h02, 0,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(1, 8'h03, 0, 1, 1, 1, 1,  1, 8'h03, 0,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(1, 8'h04, 1, 1, 1, 1, 1,  1, 8'h04, 1,  0, 8'h00, 0,  0, 1));
    // backpressure on port 1 with slot full, then release
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0,  1, 8'h04, 1,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0,  1, 8'h04, 1,  0, 8'h00, 0,  0, 1));
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 1,  1, 8'h11, 0,  0, 8'h00, 0,  1, 1));
    vecs.push_back(mk(1, 8'h12, 1, 1, 1, 1, 1,  1, 8'h12, 1,  0, 8'h00, 0,  1, 1));
    // back-to-back packet to port 2 while port 1 drains
    vecs.push_back(mk(1, 8'h21, 0, 1, 1, 1, 1,  0, 8'h00, 0,  1, 8'h21, 0,  2, 1));
    vecs.push_back(mk(1, 8'h22, 1, 0, 1, 1, 1,  0, 8'h00, 0,  1, 8'h22, 1,  2, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0,  2, 2));

    do_reset();

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge aclk);
      drive(vecs[i].tv, vecs[i].td, vecs[i].tl, vecs[i].dst, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("v%0d s_tready", i), 32'(bus.s_axis_tready), 32'(vecs[i].e_rdy));
      @(posedge aclk);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].ev1, vecs[i].ed1, vecs[i].el1,
                  vecs[i].ev2, vecs[i].ed2, vecs[i].el2, vecs[i].ec1, vecs[i].ec2);
    end

    // Counter wrap: 256 single-beat packets to port 2
    do_reset();
    @(negedge aclk);
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (256) @(posedge aclk);
    #1;
    chk("wrap pkt_cnt2 at 255", 32'(bus.pkt_cnt2), 32'd255);
    chk("wrap pkt_cnt1 at 255", 32'(bus.pkt_cnt1), 32'd0);
    @(negedge aclk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge aclk);
    #1;
    chk("wrap pkt_cnt2", 32'(bus.pkt_cnt2), 32'd0);
    chk("wrap pkt_cnt1", 32'(bus.pkt_cnt1), 32'd0);
    chk("wrap tvalid2",  32'(bus.m_axis_tvalid2), 32'd0);

    // Reset after beat 2 of a 4-beat packet to port 1
    @(negedge aclk);
    drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge aclk);
    @(negedge aclk);
    drive(1'b1, 8'h32, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge aclk);
    #1;
    chk("midrst pre tvalid1", 32'(bus.m_axis_tvalid1), 32'd1);
    chk("midrst pre tdata1",  32'(bus.m_axis_tdata1),  32'h32);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst s_tready", 32'(bus.s_axis_tready), 32'd0);
    chk_outputs("midrst", 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("postrst s_tready", 32'(bus.s_axis_tready), 32'd1);
    @(posedge aclk);
    #1;
    chk_outputs("postrst", 0, 8'h00, 0, 1, 8'h41, 0, 8'h00, 8'h00);
    @(negedge aclk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_demux.md
AXIS_DEMUX -- requirements
Module: axis_demux

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of all tdata ports.
REQ-002 aclk  input  1  sole clock; all state updates on rising edge.
REQ-003 aresetn  input  1  reset, asynchronous assert, active-low; clears all state immediately.
REQ-004 s_axis_tvalid  input  1  upstream beat valid.
REQ-005 s_axis_tready  output  1  demux can accept the current upstream beat.
REQ-006 s_axis_tdata  input  DATA_WIDTH  upstream beat data.
REQ-007 s_axis_tlast  input  1  upstream last beat of packet.
REQ-008 s_axis_tdest  input  1  destination; 0 = output 1, 1 = output 2; sampled on first beat only.
REQ-009 m_axis_tvalid1 / m_axis_tvalid2  output  1  output beat valid, per port.
REQ-010 m_axis_tready1 / m_axis_tready2  input  1  downstream ready, per port.
REQ-011 m_axis_tdata1 / m_axis_tdata2  output  DATA_WIDTH  output beat data, per port.
REQ-012 m_axis_tlast1 / m_axis_tlast2  output  1  output last beat, per port.
REQ-013 pkt_cnt1 / pkt_cnt2  output  8  packets fully delivered on each port.

Function
REQ-014 Each output port SHALL have one registered beat slot (valid, data, last) driving its m_axis_* outputs directly, with no combinational path from s_axis_* to m_axis_*.
REQ-015 FSM states SHALL be IDLE, BUSY1 and BUSY2, where BUSYn means a packet routed to port n is in progress.
REQ-016 Selected port sel SHALL be s_axis_tdest+1 in IDLE, 1 in BUSY1, and 2 in BUSY2.
REQ-017 s_axis_tready SHALL equal (!slot_valid[sel] || m_axis_treadyn[sel]), combinationally.
REQ-018 An upstream handshake (tvalid && tready) SHALL load tdata/tlast into slot[sel] and set its valid on the next edge, giving 1-cycle latency.
REQ-019 Throughput SHALL be one beat per cycle when the selected downstream holds tready high.
REQ-020 Slot n SHALL hold valid, data and last stable until m_axis_tvalidn && m_axis_treadyn; on that edge it clears unless it is reloaded in the same cycle.
REQ-021 FSM transitions SHALL be:
- IDLE -> BUSY1 or BUSY2 on an accepted non-last first beat.
- IDLE -> IDLE on an accepted first beat with tlast=1 (single-beat packet).
- BUSYn -> IDLE on an accepted beat with tlast=1.
- Otherwise the state SHALL hold.
REQ-022 s_axis_tdest SHALL be ignored on every beat except the first beat of a packet.
REQ-023 The non-selected port SHALL continue draining its slot independently while the other port is being loaded.
REQ-024 A new packet to either port SHALL be accepted in the cycle after the previous packet's tlast is accepted, with no bubble required.
REQ-025 pkt_cnt_n SHALL increment by 1 on each output handshake with m_axis_tlastn=1.
REQ-026 pkt_cnt_n SHALL wrap from 255 to 0.
REQ-027 s_axis_tvalid deasserting mid-packet SHALL leave the FSM state unchanged.

Reset
REQ-028 While aresetn=0, the block SHALL force:
- state = IDLE.
- All slot valid, data and last = 0.
- m_axis_tvalid1/2 = 0, m_axis_tdata1/2 = 0, m_axis_tlast1/2 = 0.
- pkt_cnt1 = 0, pkt_cnt2 = 0.
- s_axis_tready = 0.
REQ-029 Reset asserted mid-packet SHALL discard the partial packet and any held beats; the first beat accepted after release SHALL be treated as a new first beat.

Verification
REQ-030 Single beat: tdest=1, tdata=0xA5, tlast=1, m_axis_tready2=1 -> next cycle m_axis_tvalid2=1, tdata2=0xA5, tlast2=1; pkt_cnt2 becomes 1; port 1 stays idle.
REQ-031 Four-beat packet 0x01..0x04 to port 1, tdest toggled on beats 2-4 -> all four beats appear on port 1 on consecutive cycles, tlast only on 0x04, state returns to IDLE.
REQ-032 Backpressure: m_axis_tready1=0 with the slot full -> s_axis_tready=0 and the slot holds its data unchanged; raising tready1 -> one beat drains and s_axis_tready=1 in the same cycle.
REQ-033 Back-to-back packets to port 1 then port 2 with both readies high -> no idle cycle between them; pkt_cnt1=1 and pkt_cnt2=1.
REQ-034 Counter wrap: 256 single-beat packets to port 2 -> pkt_cnt2 reads 0x00; pkt_cnt1 stays 0x00.
REQ-035 Reset asserted after beat 2 of a 4-beat packet -> outputs go to 0 immediately; after release, a tdest=1 beat routes to port 2.
